// File: rtl/cu_fsm_mc.sv
// cu_fsm_mc: multicycle control unit for the RISC-V core.
// Sequences fetch/exec/mem/wb with variable-latency memory, bus timeout, irq and mret.
module cu_fsm_mc #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        intr,
    input  logic        mie,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        pcWrite,
    output logic        regWrite,
    output logic        memWrite,
    output logic        memRead1,
    output logic        memRead2,
    output logic        csrWrite,
    output logic        intTaken,
    output logic        mretExec,
    output logic        busErr,
    output logic [2:0]  state_o
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam bit TO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] CNT_MAX =
        CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] MRET_ENC = 32'h3020_0073;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_inc;

    logic   is_load, is_store, is_branch, is_system, is_csr, is_mret;
    logic   irq, cnt_hit;
    state_t end_st;

    assign is_load   = (ir[6:0] == OP_LOAD);
    assign is_store  = (ir[6:0] == OP_STORE);
    assign is_branch = (ir[6:0] == OP_BRANCH);
    assign is_system = (ir[6:0] == OP_SYSTEM);
    assign is_csr    = is_system && (ir[14:12] != 3'b000);
    assign is_mret   = (ir == MRET_ENC);

    // irq is only honoured where an instruction would return to FETCH
    assign irq     = intr & mie;
    assign end_st  = irq ? S_INTR : S_FETCH;
    assign cnt_hit = TO_EN && (cnt_q == CNT_MAX);

    assign state_o = state_q;

    // State and wait-counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode from present state, ir and mem_rdy
    always_comb begin
        state_d  = state_q;
        cnt_inc  = 1'b0;
        pcWrite  = 1'b0;
        regWrite = 1'b0;
        memWrite = 1'b0;
        memRead1 = 1'b0;
        memRead2 = 1'b0;
        csrWrite = 1'b0;
        intTaken = 1'b0;
        mretExec = 1'b0;
        busErr   = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead1 = 1'b1;
                if (mem_rdy) begin
                    state_d = S_EXEC;
                end else if (cnt_hit) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_inc = TO_EN;
                end
            end
            S_EXEC: begin
                if (is_load) begin
                    memRead2 = 1'b1;
                    state_d  = S_MEM;
                end else if (is_store) begin
                    memWrite = 1'b1;
                    state_d  = S_MEM;
                end else if (is_branch) begin
                    pcWrite = 1'b1;
                    state_d = end_st;
                end else if (is_system) begin
                    pcWrite = 1'b1;
                    if (is_csr) begin
                        regWrite = 1'b1;
                        csrWrite = 1'b1;
                    end else if (is_mret) begin
                        mretExec = 1'b1;
                    end
                    state_d = end_st;
                end else begin
                    pcWrite  = 1'b1;
                    regWrite = 1'b1;
                    state_d  = end_st;
                end
            end
            S_MEM: begin
                if (is_store) begin
                    memWrite = 1'b1;
                end else begin
                    memRead2 = 1'b1;
                end
                if (mem_rdy) begin
                    if (is_store) begin
                        pcWrite = 1'b1;
                        state_d = end_st;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_hit) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_inc = TO_EN;
                end
            end
            S_WB: begin
                pcWrite  = 1'b1;
                regWrite = 1'b1;
                state_d  = end_st;
            end
            S_INTR: begin
                pcWrite  = 1'b1;
                intTaken = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                pcWrite = 1'b1;
                busErr  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Wait counter restarts on any state change
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_cu_fsm_mc.sv
// tb_cu_fsm_mc: directed checks of the multicycle control unit.
// Observed vector is {state_o, pc, rw, mw, mr1, mr2, csr, int, mret, berr}.
module tb_cu_fsm_mc;

    localparam logic [8:0] PC  = 9'h100;
    localparam logic [8:0] RW  = 9'h080;
    localparam logic [8:0] MW  = 9'h040;
    localparam logic [8:0] MR1 = 9'h020;
    localparam logic [8:0] MR2 = 9'h010;
    localparam logic [8:0] CS  = 9'h008;
    localparam logic [8:0] IT  = 9'h004;
    localparam logic [8:0] MX  = 9'h002;
    localparam logic [8:0] BE  = 9'h001;

    logic        clk;
    logic        RST;
    logic        intr;
    logic        mie;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        pcWrite, regWrite, memWrite, memRead1, memRead2;
    logic        csrWrite, intTaken, mretExec, busErr;
    logic [2:0]  state_o;
    logic [11:0] obs;

    int passed = 0;
    int total  = 0;

    cu_fsm_mc #(.TIMEOUT_CYC(4)) dut (
        .clk(clk),
        .RST(RST),
        .intr(intr),
        .mie(mie),
        .ir(ir),
        .mem_rdy(mem_rdy),
        .pcWrite(pcWrite),
        .regWrite(regWrite),
        .memWrite(memWrite),
        .memRead1(memRead1),
        .memRead2(memRead2),
        .csrWrite(csrWrite),
        .intTaken(intTaken),
        .mretExec(mretExec),
        .busErr(busErr),
        .state_o(state_o)
    );

    assign obs = {state_o, pcWrite, regWrite, memWrite, memRead1,
                  memRead2, csrWrite, intTaken, mretExec, busErr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; intr = 1'b0; mie = 1'b0; ir = 32'h0; mem_rdy = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        total++;
        if (obs !== {3'd0, MR1})
            $display("FAIL reset obs=%h exp=%h", obs, {3'd0, MR1});
        else passed++;
    endtask

    task automatic test_alu();
        logic [11:0] e [4];
        e = '{{3'd0, MR1}, {3'd1, PC | RW}, {3'd0, MR1}, {3'd1, PC | RW}};
        ir = 32'h0000_0013; mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL alu[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_load_wait();
        logic        r [8];
        logic [11:0] e [8];
        r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e = '{{3'd0, MR1}, {3'd1, MR2}, {3'd2, MR2}, {3'd2, MR2},
              {3'd2, MR2}, {3'd2, MR2}, {3'd3, PC | RW}, {3'd0, MR1}};
        ir = 32'h0000_2083;
        for (int i = 0; i < 8; i++) begin
            mem_rdy = r[i];
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL load[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            if (i < 7) tick();
        end
    endtask

    task automatic test_store_irq();
        logic [11:0] e [5];
        e = '{{3'd0, MR1}, {3'd1, MW}, {3'd2, MW | PC},
              {3'd4, PC | IT}, {3'd0, MR1}};
        ir = 32'h0011_2023; mem_rdy = 1'b1; intr = 1'b1; mie = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL st_irq[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            if (i < 4) tick();
        end
        mie = 1'b0;
        e = '{{3'd0, MR1}, {3'd1, MW}, {3'd2, MW | PC},
              {3'd0, MR1}, {3'd1, MW}};
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL st_nomie[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            if (i < 4) tick();
        end
        tick();
        mem_rdy = 1'b1;
        tick();
        intr = 1'b0;
    endtask

    task automatic test_timeout();
        logic        r [6];
        logic [11:0] e [6];
        ir = 32'h0000_0013;
        r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        e = '{{3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1},
              {3'd5, PC | BE}, {3'd0, MR1}};
        for (int i = 0; i < 6; i++) begin
            mem_rdy = r[i];
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL to_trap[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            if (i < 5) tick();
        end
        r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e = '{{3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1},
              {3'd1, PC | RW}, {3'd0, MR1}};
        for (int i = 0; i < 6; i++) begin
            mem_rdy = r[i];
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL to_last[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            if (i < 5) tick();
        end
    endtask

    task automatic test_trap_vs_irq();
        logic        r [8];
        logic [11:0] e [8];
        ir = 32'h0000_0013; intr = 1'b1; mie = 1'b1;
        r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e = '{{3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1},
              {3'd5, PC | BE}, {3'd0, MR1}, {3'd1, PC | RW},
              {3'd4, PC | IT}};
        for (int i = 0; i < 8; i++) begin
            mem_rdy = r[i];
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL trap_irq[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            tick();
        end
        intr = 1'b0;
    endtask

    task automatic test_system();
        logic [31:0] ins [4];
        logic [11:0] e   [4];
        ins = '{32'h3020_0073, 32'h3401_1073, 32'h0000_0073, 32'h0000_0063};
        e   = '{{3'd1, PC | MX}, {3'd1, PC | RW | CS}, {3'd1, PC},
                {3'd1, PC}};
        mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ir = ins[i];
            tick();
            total++;
            if (obs !== e[i])
                $display("FAIL sys[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_reset_mid_store();
        logic [11:0] e [6];
        ir = 32'h0011_2023; mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        #1;
        total++;
        if (obs !== {3'd2, MW})
            $display("FAIL rst_pre obs=%h exp=%h", obs, {3'd2, MW});
        else passed++;
        tick();
        RST = 1'b0;
        e = '{{3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1}, {3'd0, MR1},
              {3'd5, PC | BE}, {3'd0, MR1}};
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (obs !== e[i])
                $display("FAIL rst_mid[%0d] obs=%h exp=%h", i, obs, e[i]);
            else passed++;
            if (i < 5) tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store_irq();
        test_timeout();
        test_trap_vs_irq();
        test_system();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
